// File: rtl/alu_operand_stage.sv
// Operand-capture stage ahead of the ALU: one-entry valid/ready pipeline register
// with isolated (hold-on-idle) operands and an idle-timeout clock-enable request.
module alu_operand_stage #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned OP_W        = 4,
    parameter int unsigned IDLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [OP_W-1:0]  out_op,
    output logic             out_cin,
    output logic             gate_en,
    output logic             idle,
    output logic [15:0]      txn_count
);

    localparam int unsigned CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned TXN_W = 16;
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic [OP_W-1:0]  r_out_op;
    logic             r_out_cin;
    logic [TXN_W-1:0] r_txn_count;
    logic [CNT_W-1:0] r_idle_cnt;

    logic w_in_ready;
    logic w_accept;
    logic w_active;

    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_accept   = in_valid & w_in_ready;
    assign w_active   = in_valid | r_out_valid;

    // Valid flag: set on accept, cleared when the held entry drains with nothing behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Operands load only on accept so the datapath inputs never toggle between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_a   <= '0;
            r_out_b   <= '0;
            r_out_op  <= '0;
            r_out_cin <= 1'b0;
        end else if (w_accept) begin
            r_out_a   <= in_a;
            r_out_b   <= in_b;
            r_out_op  <= in_op;
            r_out_cin <= in_cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn_count <= '0;
        end else if (w_accept) begin
            r_txn_count <= r_txn_count + TXN_W'(1);
        end
    end

    // Counts quiet cycles since the last activity, saturating at the gate-off threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= IDLE_MAX;
        end else if (w_active) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != IDLE_MAX) begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_op    = r_out_op;
    assign out_cin   = r_out_cin;
    assign txn_count = r_txn_count;

    // in_valid opens the gate in the same cycle so the accepting edge is clocked.
    assign gate_en = in_valid | (r_idle_cnt != IDLE_MAX);
    assign idle    = (r_idle_cnt == IDLE_MAX) & ~in_valid & ~r_out_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: randomized and directed stimulus
// compared against a transaction-level reference model.
module tb_alu_operand_stage;

    localparam int WIDTH = 16;
    localparam int OP_W  = 4;
    localparam int IDLE  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [OP_W-1:0]  in_op = '0;
    logic             in_cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [OP_W-1:0]  out_op;
    logic             out_cin;
    logic             gate_en;
    logic             idle;
    logic [15:0]      txn_count;

    int tests_run = 0;
    int tests_failed = 0;

    alu_operand_stage #(.WIDTH(WIDTH), .OP_W(OP_W), .IDLE_CYCLES(IDLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_cin(out_cin),
        .gate_en(gate_en), .idle(idle), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    // Reference model: the held transaction, number accepted, cycles since last activity.
    logic             m_valid;
    logic [WIDTH-1:0] m_a, m_b;
    logic [OP_W-1:0]  m_op;
    logic             m_cin;
    int               m_count;
    int               m_since;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_cin = 1'b0;
            m_count = 0;
            m_since = IDLE;
        end else begin
            bit took, busy;
            took = in_valid && (!m_valid || out_ready);
            busy = in_valid || m_valid;
            if (took) begin
                m_valid = 1'b1; m_a = in_a; m_b = in_b; m_op = in_op; m_cin = in_cin;
                m_count = m_count + 1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            m_since = busy ? 0 : m_since + 1;
        end
    end

    wire [56:0] dut_vec = {in_ready, out_valid, out_a, out_b, out_op, out_cin, gate_en, idle, txn_count};

    function automatic logic [56:0] exp_vec();
        logic rdy, g, i;
        logic [15:0] c;
        rdy = !m_valid || out_ready;
        g   = in_valid || (m_since < IDLE);
        i   = (m_since >= IDLE) && !in_valid && !m_valid;
        c   = m_count[15:0];
        return {rdy, m_valid, m_a, m_b, m_op, m_cin, g, i, c};
    endfunction

    task automatic drive(input bit v, input bit rdy, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input bit cin);
        in_valid = v; out_ready = rdy; in_a = a; in_b = b; in_op = op; in_cin = cin;
    endtask

    task automatic drive_rand(input bit v, input bit rdy);
        drive(v, rdy, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, '0, '0, '0, 0);
        #1;
        tests_run++;
        if (dut_vec !== exp_vec()) begin
            tests_failed++; $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_vec());
        end
        in_valid = 1'b1; #1;
        tests_run++;
        if ({gate_en, idle} !== 2'b10) begin
            tests_failed++; $display("FAIL reset_gate_follows_valid got=%b exp=10", {gate_en, idle});
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk); drive(1, 1, 16'h7FFF, 16'h0001, 4'h0, 0); #1;
        tests_run++;
        if (dut_vec !== exp_vec()) begin
            tests_failed++; $display("FAIL single_offer got=%h exp=%h", dut_vec, exp_vec());
        end
        @(negedge clk); in_valid = 1'b0; #1;
        tests_run++;
        if ({out_valid, out_a, out_b} !== {1'b1, 16'h7FFF, 16'h0001}) begin
            tests_failed++; $display("FAIL single_out got=%h exp=%h", {out_valid, out_a, out_b}, {1'b1, 16'h7FFF, 16'h0001});
        end
        @(negedge clk); #1;
        tests_run++;
        if ({out_valid, out_a, txn_count} !== {1'b0, 16'h7FFF, 16'd1}) begin
            tests_failed++; $display("FAIL single_drained got=%h exp=%h", {out_valid, out_a, txn_count}, {1'b0, 16'h7FFF, 16'd1});
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = m_count;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); drive_rand(1, 1); #1;
            tests_run++;
            if (dut_vec !== exp_vec() || in_ready !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
                tests_failed++; $display("FAIL b2b_cycle%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        @(negedge clk); in_valid = 1'b0; #1;
        tests_run++;
        if (txn_count !== 16'(start + 8) || dut_vec !== exp_vec()) begin
            tests_failed++; $display("FAIL b2b_count got=%0d exp=%0d", txn_count, start + 8);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        held = 16'h1234;
        @(negedge clk); drive(1, 0, held, 16'h5555, 4'h3, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1, 0, 16'h8000, 16'h0F0F, 4'h9, 0); #1;
            tests_run++;
            if (in_ready !== 1'b0 || out_a !== held || out_valid !== 1'b1 || dut_vec !== exp_vec()) begin
                tests_failed++; $display("FAIL stall_hold%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        @(negedge clk); out_ready = 1'b1; #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_a !== held) begin
            tests_failed++; $display("FAIL stall_release got=%b/%h exp=1/%h", in_ready, out_a, held);
        end
        @(negedge clk); in_valid = 1'b0; #1;
        tests_run++;
        if (out_a !== 16'h8000 || out_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            tests_failed++; $display("FAIL stall_load got=%h exp=%h", out_a, 16'h8000);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_clock_gating();
        @(negedge clk); drive_rand(1, 1);
        @(negedge clk); in_valid = 1'b0;
        for (int k = 0; k < IDLE + 2; k++) begin
            @(negedge clk); #1;
            tests_run++;
            if (k < IDLE ? (gate_en !== 1'b1 || idle !== 1'b0) : (gate_en !== 1'b0 || idle !== 1'b1)) begin
                tests_failed++; $display("FAIL gate_tail%0d got=%b%b exp=%0s", k, gate_en, idle, k < IDLE ? "10" : "01");
            end
        end
        @(negedge clk); drive_rand(1, 1); #1;
        tests_run++;
        if (gate_en !== 1'b1 || idle !== 1'b0 || dut_vec !== exp_vec()) begin
            tests_failed++; $display("FAIL gate_wake got=%b%b exp=10", gate_en, idle);
        end
        @(negedge clk); in_valid = 1'b0; #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive_rand(($urandom_range(0, 3) != 0) && (i % 60 < 40), $urandom_range(0, 2) != 0);
            #1;
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++; $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); drive_rand(1, 0);
        @(negedge clk); in_valid = 1'b0; #1;
        tests_run++;
        if (out_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            tests_failed++; $display("FAIL areset_setup got=%h exp=%h", dut_vec, exp_vec());
        end
        #1 rst_n = 1'b0; #1;
        tests_run++;
        if ({out_valid, txn_count, gate_en, idle} !== {1'b0, 16'd0, 1'b0, 1'b1} || dut_vec !== exp_vec()) begin
            tests_failed++; $display("FAIL areset_immediate got=%h exp=%h", dut_vec, exp_vec());
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk); drive_rand(1, 1);
            if (i == 65535) begin
                #1;
                tests_run++;
                if (txn_count !== 16'hFFFF || dut_vec !== exp_vec()) begin
                    tests_failed++; $display("FAIL wrap_ffff got=%h exp=ffff", txn_count);
                end
            end
        end
        @(negedge clk); in_valid = 1'b0; #1;
        tests_run++;
        if (txn_count !== 16'h0000 || dut_vec !== exp_vec()) begin
            tests_failed++; $display("FAIL wrap_zero got=%h exp=0000", txn_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_clock_gating();
        test_random();
        test_async_reset();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
